// File: rtl/can_tx_arb_pkg.sv
// rtl/can_tx_arb_pkg.sv - shared types and defaults for the CAN Tx mailbox arbiter
package can_tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    ABORTED = 2'd1,
    FAILED  = 2'd2
  } tx_stat_e;

  localparam int NUM_MB_DEF    = 4;
  localparam int MSG_W_DEF     = 128;
  localparam int ARB_W_DEF     = 32;
  localparam int MAX_RETRY_DEF = 3;

  // Index width for n sources, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/can_tx_arb_min_tree.sv
// rtl/can_tx_arb_min_tree.sv - combinational lowest-key finder, ties go to the lower index
module can_tx_arb_min_tree #(
  parameter int N     = 5,
  parameter int KEY_W = 32,
  parameter int IW    = 3
) (
  input  logic [N-1:0][KEY_W-1:0] i_key,
  input  logic [N-1:0]            i_valid,
  output logic [IW-1:0]           o_idx,
  output logic                    o_valid
);

  logic [KEY_W-1:0] best;

  // Scan upward; strict less-than keeps the earlier (lower) index on equal keys
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    best    = '0;
    for (int i = 0; i < N; i++) begin
      if (i_valid[i] && (!o_valid || (i_key[i] < best))) begin
        o_valid = 1'b1;
        best    = i_key[i];
        o_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/can_tx_mailbox_arbiter.sv
// rtl/can_tx_mailbox_arbiter.sv - Tx mailboxes plus FIFO head, priority pick, BSP handoff, abort and retry
module can_tx_mailbox_arbiter
  import can_tx_arb_pkg::*;
#(
  parameter int NUM_MB    = NUM_MB_DEF,
  parameter int MSG_W     = MSG_W_DEF,
  parameter int ARB_W     = ARB_W_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  localparam int MBW      = idx_w(NUM_MB),
  localparam int SW       = MBW + 1
) (
  input  logic              i_sys_clk,
  input  logic              i_reset_n,
  input  logic              i_cen,
  input  logic              i_mb_load,
  input  logic [MBW-1:0]    i_mb_sel,
  input  logic [MSG_W-1:0]  i_mb_data,
  input  logic [NUM_MB-1:0] i_mb_abort,
  output logic [NUM_MB-1:0] o_mb_full,
  output logic              o_load_err,
  input  logic              i_fifo_empty,
  input  logic [MSG_W-1:0]  i_fifo_data,
  output logic              o_fifo_r_en,
  output logic [MSG_W-1:0]  o_send_data,
  output logic              o_send_en,
  input  logic              i_busy_can,
  input  logic              i_txok,
  input  logic              i_arblst,
  input  logic              i_tx_error,
  output logic              o_done,
  output logic [SW-1:0]     o_done_src,
  output logic [1:0]        o_done_stat,
  output logic              o_busy
);

  tx_state_e              state, state_nxt;
  tx_stat_e               done_stat, stat_nxt;
  logic [NUM_MB-1:0]      mb_full;
  logic [NUM_MB-1:0]      abort_rpt;
  logic [MSG_W-1:0]       mb_data [NUM_MB];
  logic [SW-1:0]          cur_idx;
  logic                   cur_is_fifo;
  logic                   abort_hold;
  logic                   abort_eff;
  logic [7:0]             retry_cnt;
  logic                   retry_last;
  logic [NUM_MB-1:0]      inflight;
  logic [NUM_MB-1:0]      load_hit;
  logic                   load_ok;
  logic [NUM_MB:0]        cand_valid;
  logic [NUM_MB:0][ARB_W-1:0] cand_key;
  logic [SW-1:0]          win_idx;
  logic                   win_valid;
  logic [MSG_W-1:0]       win_data;
  logic                   rpt_pend;
  logic [SW-1:0]          rpt_idx;

  assign cur_is_fifo = (cur_idx == SW'(NUM_MB));
  assign rpt_pend    = |abort_rpt;
  assign abort_eff   = abort_hold | (|(i_mb_abort & inflight));
  assign retry_last  = (MAX_RETRY != 0) && ((retry_cnt + 8'd1) == 8'(MAX_RETRY));
  assign load_ok     = |(load_hit & ~mb_full);
  assign o_mb_full   = mb_full;

  // Candidate set: idle full mailboxes (minus same-cycle aborts while arbitrating) and the FIFO head
  always_comb begin
    inflight   = '0;
    load_hit   = '0;
    cand_valid = '0;
    cand_key   = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      inflight[i]   = ((state == SEND) || (state == WAIT) || (state == DONE)) && (cur_idx == SW'(i));
      load_hit[i]   = i_mb_load && (i_mb_sel == MBW'(i));
      cand_valid[i] = mb_full[i] && !inflight[i] && !((state == ARB) && i_mb_abort[i]);
      cand_key[i]   = mb_data[i][MSG_W-1 -: ARB_W];
    end
    cand_valid[NUM_MB] = !i_fifo_empty;
    cand_key[NUM_MB]   = i_fifo_data[MSG_W-1 -: ARB_W];
  end

  can_tx_arb_min_tree #(
    .N     (NUM_MB + 1),
    .KEY_W (ARB_W),
    .IW    (SW)
  ) u_min_tree (
    .i_key   (cand_key),
    .i_valid (cand_valid),
    .o_idx   (win_idx),
    .o_valid (win_valid)
  );

  // Winner payload mux and lowest pending abort report
  always_comb begin
    win_data = i_fifo_data;
    rpt_idx  = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (win_idx == SW'(i)) win_data = mb_data[i];
    end
    for (int i = NUM_MB - 1; i >= 0; i--) begin
      if (abort_rpt[i]) rpt_idx = SW'(i);
    end
  end

  // State register
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state and completion status
  always_comb begin
    state_nxt = state;
    stat_nxt  = done_stat;
    case (state)
      IDLE: if (!rpt_pend && i_cen && win_valid) state_nxt = ARB;
      ARB:  state_nxt = win_valid ? SEND : IDLE;
      SEND: begin
        if (!i_cen)          state_nxt = IDLE;
        else if (i_busy_can) state_nxt = WAIT;
      end
      WAIT: begin
        if (i_txok) begin
          state_nxt = DONE;
          stat_nxt  = OK;
        end else if (i_arblst) begin
          if (abort_eff) begin
            state_nxt = DONE;
            stat_nxt  = ABORTED;
          end else begin
            state_nxt = IDLE;
          end
        end else if (i_tx_error) begin
          if (abort_eff) begin
            state_nxt = DONE;
            stat_nxt  = ABORTED;
          end else if (retry_last) begin
            state_nxt = DONE;
            stat_nxt  = FAILED;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; idle abort reports take the done port ahead of new arbitration
  always_comb begin
    o_send_en   = (state == SEND);
    o_busy      = (state != IDLE);
    o_fifo_r_en = (state == DONE) && cur_is_fifo;
    o_done      = 1'b0;
    o_done_src  = '0;
    o_done_stat = OK;
    if (state == DONE) begin
      o_done      = 1'b1;
      o_done_src  = cur_idx;
      o_done_stat = done_stat;
    end else if ((state == IDLE) && rpt_pend) begin
      o_done      = 1'b1;
      o_done_src  = rpt_idx;
      o_done_stat = ABORTED;
    end
  end

  // Mailbox contents, abort bookkeeping, selected message and retry count
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mb_full     <= '0;
      abort_rpt   <= '0;
      cur_idx     <= '0;
      abort_hold  <= 1'b0;
      retry_cnt   <= '0;
      done_stat   <= OK;
      o_send_data <= '0;
      o_load_err  <= 1'b0;
      for (int i = 0; i < NUM_MB; i++) mb_data[i] <= '0;
    end else begin
      o_load_err <= i_mb_load && !load_ok;
      done_stat  <= stat_nxt;
      abort_hold <= ((state == SEND) || (state == WAIT)) &&
                    ((state_nxt == SEND) || (state_nxt == WAIT)) && abort_eff;
      for (int i = 0; i < NUM_MB; i++) begin
        if ((state == IDLE) && rpt_pend && (rpt_idx == SW'(i))) abort_rpt[i] <= 1'b0;
        if ((state == DONE) && inflight[i]) begin
          mb_full[i] <= 1'b0;
        end else if (i_mb_abort[i] && mb_full[i] && !inflight[i]) begin
          mb_full[i]   <= 1'b0;
          abort_rpt[i] <= 1'b1;
        end else if ((state == SEND) && !i_cen && abort_eff && inflight[i]) begin
          mb_full[i]   <= 1'b0;
          abort_rpt[i] <= 1'b1;
        end else if (load_hit[i] && !mb_full[i]) begin
          mb_full[i] <= 1'b1;
          mb_data[i] <= i_mb_data;
        end
      end
      if ((state == ARB) && win_valid) begin
        cur_idx     <= win_idx;
        o_send_data <= win_data;
      end
      if (state == DONE) begin
        retry_cnt <= '0;
      end else if ((state == WAIT) && !i_txok && !i_arblst && i_tx_error) begin
        retry_cnt <= retry_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_can_tx_mailbox_arbiter.sv
// tb/tb_can_tx_mailbox_arbiter.sv - directed self-checking bench for can_tx_mailbox_arbiter
module tb_can_tx_mailbox_arbiter;

  logic         clk = 1'b0;
  logic         i_reset_n;
  logic         i_cen;
  logic         i_mb_load;
  logic [1:0]   i_mb_sel;
  logic [127:0] i_mb_data;
  logic [3:0]   i_mb_abort;
  logic [3:0]   o_mb_full;
  logic         o_load_err;
  logic         i_fifo_empty;
  logic [127:0] i_fifo_data;
  logic         o_fifo_r_en;
  logic [127:0] o_send_data;
  logic         o_send_en;
  logic         i_busy_can;
  logic         i_txok;
  logic         i_arblst;
  logic         i_tx_error;
  logic         o_done;
  logic [2:0]   o_done_src;
  logic [1:0]   o_done_stat;
  logic         o_busy;

  int n_checks = 0;
  int n_errors = 0;

  can_tx_mailbox_arbiter dut (
    .i_sys_clk    (clk),
    .i_reset_n    (i_reset_n),
    .i_cen        (i_cen),
    .i_mb_load    (i_mb_load),
    .i_mb_sel     (i_mb_sel),
    .i_mb_data    (i_mb_data),
    .i_mb_abort   (i_mb_abort),
    .o_mb_full    (o_mb_full),
    .o_load_err   (o_load_err),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_r_en  (o_fifo_r_en),
    .o_send_data  (o_send_data),
    .o_send_en    (o_send_en),
    .i_busy_can   (i_busy_can),
    .i_txok       (i_txok),
    .i_arblst     (i_arblst),
    .i_tx_error   (i_tx_error),
    .o_done       (o_done),
    .o_done_src   (o_done_src),
    .o_done_stat  (o_done_stat),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] msg(input logic [31:0] key, input logic [7:0] tag);
    return {key, 88'h0, tag};
  endfunction

  task automatic tick();
    @(negedge clk);
    i_txok     = 1'b0;
    i_arblst   = 1'b0;
    i_tx_error = 1'b0;
    i_mb_load  = 1'b0;
    i_mb_abort = '0;
  endtask

  task automatic load(input logic [1:0] sel, input logic [31:0] key, input logic [7:0] tag);
    i_mb_load = 1'b1;
    i_mb_sel  = sel;
    i_mb_data = msg(key, tag);
    tick();
  endtask

  task automatic wait_send(input string tag, input logic [31:0] key, input logic [7:0] mtag);
    int n = 0;
    while (!o_send_en && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_send_en"}, 64'(o_send_en), 64'd1);
    chk({tag, "_key"}, 64'(o_send_data[127:96]), 64'(key));
    chk({tag, "_tag"}, 64'(o_send_data[7:0]), 64'(mtag));
  endtask

  // Called with o_send_en high: BSP accepts, then the given bus event is driven in WAIT
  task automatic bus_event(input int ev);
    i_busy_can = 1'b1;
    tick();
    i_busy_can = 1'b0;
    case (ev)
      0:       i_txok     = 1'b1;
      1:       i_arblst   = 1'b1;
      default: i_tx_error = 1'b1;
    endcase
  endtask

  task automatic wait_done(input string tag, input int src, input int stat);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!o_done && n < 20);
    chk({tag, "_done"}, 64'(o_done), 64'd1);
    chk({tag, "_src"}, 64'(o_done_src), 64'(src));
    chk({tag, "_stat"}, 64'(o_done_stat), 64'(stat));
    chk({tag, "_fifo_r_en"}, 64'(o_fifo_r_en), 64'(src == 4));
    if (o_fifo_r_en) i_fifo_empty = 1'b1;
  endtask

  initial begin
    bit seen;
    i_reset_n    = 1'b0;
    i_cen        = 1'b0;
    i_mb_load    = 1'b0;
    i_mb_sel     = '0;
    i_mb_data    = '0;
    i_mb_abort   = '0;
    i_fifo_empty = 1'b1;
    i_fifo_data  = '0;
    i_busy_can   = 1'b0;
    i_txok       = 1'b0;
    i_arblst     = 1'b0;
    i_tx_error   = 1'b0;
    repeat (3) tick();
    chk("rst_mb_full", 64'(o_mb_full), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_send_en", 64'(o_send_en), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    i_reset_n = 1'b1;
    tick();

    // Priority order: MB2 (0x100) beats FIFO (0x100) on index, MB0 (0x200) last
    load(2'd2, 32'h100, 8'd2);
    load(2'd0, 32'h200, 8'd0);
    i_fifo_empty = 1'b0;
    i_fifo_data  = msg(32'h100, 8'd9);
    chk("t1_full", 64'(o_mb_full), 64'b0101);
    i_cen = 1'b1;
    tick();
    chk("t1_lat1_send_en", 64'(o_send_en), 64'd0);
    chk("t1_lat1_busy", 64'(o_busy), 64'd1);
    tick();
    chk("t1_lat2_send_en", 64'(o_send_en), 64'd1);
    wait_send("t1a", 32'h100, 8'd2);
    bus_event(0);
    wait_done("t1a", 2, 0);
    tick();
    chk("t1a_full", 64'(o_mb_full), 64'b0001);
    wait_send("t1b", 32'h100, 8'd9);
    bus_event(0);
    wait_done("t1b", 4, 0);
    wait_send("t1c", 32'h200, 8'd0);
    bus_event(0);
    wait_done("t1c", 0, 0);
    tick();
    chk("t1_empty", 64'(o_mb_full), 64'd0);

    // Arbitration loss: no report, message re-sent, then OK
    load(2'd1, 32'h50, 8'd1);
    wait_send("t2a", 32'h50, 8'd1);
    bus_event(1);
    tick();
    chk("t2_no_done", 64'(o_done), 64'd0);
    chk("t2_still_full", 64'(o_mb_full), 64'b0010);
    wait_send("t2b", 32'h50, 8'd1);
    bus_event(0);
    wait_done("t2", 1, 0);
    tick();
    chk("t2_cleared", 64'(o_mb_full), 64'd0);

    // Three bus errors exhaust the retry budget
    load(2'd0, 32'h10, 8'd0);
    for (int r = 0; r < 3; r++) begin
      wait_send($sformatf("t3_try%0d", r), 32'h10, 8'd0);
      bus_event(2);
      if (r < 2) begin
        tick();
        chk($sformatf("t3_no_done%0d", r), 64'(o_done), 64'd0);
      end
    end
    wait_done("t3", 0, 2);
    tick();
    chk("t3_cleared", 64'(o_mb_full), 64'd0);

    // Abort idle MB3 and in-flight MB0 while MB0 waits; txok wins for MB0
    i_cen = 1'b0;
    load(2'd0, 32'h10, 8'd0);
    load(2'd3, 32'h300, 8'd3);
    i_cen = 1'b1;
    wait_send("t4", 32'h10, 8'd0);
    i_busy_can = 1'b1;
    tick();
    i_busy_can = 1'b0;
    i_mb_abort = 4'b1000;
    tick();
    chk("t4_mb3_cleared", 64'(o_mb_full), 64'b0001);
    i_mb_abort = 4'b0001;
    tick();
    i_txok = 1'b1;
    wait_done("t4_mb0", 0, 0);
    wait_done("t4_mb3", 3, 1);
    tick();
    chk("t4_no_done", 64'(o_done), 64'd0);
    chk("t4_empty", 64'(o_mb_full), 64'd0);

    // In-flight abort with arbitration loss in the same cycle -> ABORTED
    load(2'd1, 32'h20, 8'd1);
    wait_send("t4b", 32'h20, 8'd1);
    i_busy_can = 1'b1;
    tick();
    i_busy_can = 1'b0;
    i_mb_abort = 4'b0010;
    i_arblst   = 1'b1;
    wait_done("t4b", 1, 1);
    tick();
    chk("t4b_empty", 64'(o_mb_full), 64'd0);

    // Abort of an empty mailbox produces nothing
    i_mb_abort = 4'b0100;
    tick();
    tick();
    chk("t4c_no_done", 64'(o_done), 64'd0);

    // Load into a full mailbox is refused; core disable in SEND withdraws the request
    i_cen = 1'b0;
    load(2'd1, 32'h40, 8'd1);
    chk("t5_full", 64'(o_mb_full), 64'b0010);
    chk("t5_no_err", 64'(o_load_err), 64'd0);
    load(2'd1, 32'h41, 8'd7);
    chk("t5_load_err", 64'(o_load_err), 64'd1);
    tick();
    chk("t5_load_err_pulse", 64'(o_load_err), 64'd0);
    i_cen = 1'b1;
    wait_send("t5a", 32'h40, 8'd1);
    i_cen = 1'b0;
    tick();
    chk("t5_send_drop", 64'(o_send_en), 64'd0);
    chk("t5_idle", 64'(o_busy), 64'd0);
    chk("t5_no_done", 64'(o_done), 64'd0);
    chk("t5_kept", 64'(o_mb_full), 64'b0010);
    i_cen = 1'b1;
    wait_send("t5b", 32'h40, 8'd1);
    bus_event(0);
    wait_done("t5", 1, 0);

    // Reset during WAIT clears everything at once, no report afterwards
    load(2'd2, 32'h70, 8'd2);
    wait_send("t6", 32'h70, 8'd2);
    i_busy_can = 1'b1;
    tick();
    i_busy_can = 1'b0;
    #2 i_reset_n = 1'b0;
    #1;
    chk("t6_busy", 64'(o_busy), 64'd0);
    chk("t6_send_en", 64'(o_send_en), 64'd0);
    chk("t6_mb_full", 64'(o_mb_full), 64'd0);
    chk("t6_send_data", 64'(o_send_data[127:64]), 64'd0);
    tick();
    tick();
    i_reset_n = 1'b1;
    i_txok    = 1'b1;
    seen      = 1'b0;
    repeat (6) begin
      tick();
      if (o_done) seen = 1'b1;
    end
    chk("t6_no_done", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
